// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: runs MULT/MULTU through the pipelined multiplier and DIV/DIVU
// through the AXI-stream dividers, stalling EX until a single HI/LO write.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        mul_signed,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [63:0] mul_p,
  output logic        div_signed,
  output logic [31:0] div_dividend_tdata,
  output logic [31:0] div_divisor_tdata,
  output logic        div_dividend_tvalid,
  output logic        div_divisor_tvalid,
  input  logic        div_dividend_tready,
  input  logic        div_divisor_tready,
  input  logic        div_dout_tvalid,
  input  logic [63:0] div_dout_tdata,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [2:0]  dbg_state
);

  // Handshake rules: a divider input beat transfers on a cycle where tvalid and
  // tready are both high at the rising edge; tvalid, once raised, stays high with
  // stable tdata until that transfer. The divider output has no back-pressure:
  // each cycle with div_dout_tvalid high carries exactly one result beat.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_WAIT  = 3'd1,
    S_DIV_SEND  = 3'd2,
    S_DIV_WAIT  = 3'd3,
    S_DIV_DRAIN = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam int unsigned CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             mul_signed_q, mul_signed_d;
  logic             div_signed_q, div_signed_d;
  logic             dvd_valid_q, dvd_valid_d;
  logic             dvs_valid_q, dvs_valid_d;
  logic             dvd_sent_q, dvd_sent_d;
  logic             dvs_sent_q, dvs_sent_d;
  logic             cancel_q, cancel_d;

  logic             muldiv_req;
  logic             accept;
  logic             dvd_hs;
  logic             dvs_hs;
  logic             dvd_done;
  logic             dvs_done;
  logic             both_sent;

  assign muldiv_req = op_valid & ~op[2];
  assign accept     = (state_q == S_IDLE) & muldiv_req & ~flush;
  assign dvd_hs     = dvd_valid_q & div_dividend_tready;
  assign dvs_hs     = dvs_valid_q & div_divisor_tready;
  assign dvd_done   = dvd_sent_q | dvd_hs;
  assign dvs_done   = dvs_sent_q | dvs_hs;
  assign both_sent  = dvd_done & dvs_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_signed_q <= 1'b0;
      div_signed_q <= 1'b0;
      dvd_valid_q  <= 1'b0;
      dvs_valid_q  <= 1'b0;
      dvd_sent_q   <= 1'b0;
      dvs_sent_q   <= 1'b0;
      cancel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_signed_q <= mul_signed_d;
      div_signed_q <= div_signed_d;
      dvd_valid_q  <= dvd_valid_d;
      dvs_valid_q  <= dvs_valid_d;
      dvd_sent_q   <= dvd_sent_d;
      dvs_sent_q   <= dvs_sent_d;
      cancel_q     <= cancel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = op[1] ? S_DIV_SEND : S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (flush)              state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_DONE;
      end
      S_DIV_SEND: begin
        // A cancelled request still finishes its transfers, then drains the result.
        if (both_sent) state_d = (cancel_q | flush) ? S_DIV_DRAIN : S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        // A flush coinciding with the result beat simply drops that beat.
        if (div_dout_tvalid)    state_d = flush ? S_IDLE : S_DONE;
        else if (flush)         state_d = S_DIV_DRAIN;
      end
      S_DIV_DRAIN: begin
        if (div_dout_tvalid)    state_d = S_IDLE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_signed_d = mul_signed_q;
    div_signed_d = div_signed_q;
    dvd_valid_d  = dvd_valid_q;
    dvs_valid_d  = dvs_valid_q;
    dvd_sent_d   = dvd_sent_q;
    dvs_sent_d   = dvs_sent_q;
    cancel_d     = cancel_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d          = src_a;
          b_d          = src_b;
          mul_signed_d = ~op[1] & ~op[0];
          div_signed_d = op[1] & ~op[0];
          cnt_d        = CNT_W'(MUL_LAT);
          dvd_valid_d  = op[1];
          dvs_valid_d  = op[1];
          dvd_sent_d   = 1'b0;
          dvs_sent_d   = 1'b0;
          cancel_d     = 1'b0;
        end
      end
      S_MUL_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!flush) begin
          hi_d = mul_p[63:32];
          lo_d = mul_p[31:0];
        end
      end
      S_DIV_SEND: begin
        dvd_valid_d = dvd_valid_q & ~div_dividend_tready;
        dvs_valid_d = dvs_valid_q & ~div_divisor_tready;
        if (both_sent) begin
          dvd_sent_d = 1'b0;
          dvs_sent_d = 1'b0;
          cancel_d   = 1'b0;
        end else begin
          dvd_sent_d = dvd_done;
          dvs_sent_d = dvs_done;
          cancel_d   = cancel_q | flush;
        end
      end
      S_DIV_WAIT: begin
        if (div_dout_tvalid && !flush) begin
          lo_d = div_dout_tdata[63:32];
          hi_d = div_dout_tdata[31:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    stall               = 1'b0;
    hilo_we             = 1'b0;
    if (!flush) begin
      case (state_q)
        S_MUL_WAIT, S_DIV_SEND, S_DIV_WAIT: stall = 1'b1;
        S_IDLE, S_DIV_DRAIN:                stall = muldiv_req;
        default:                            stall = 1'b0;
      endcase
      hilo_we = (state_q == S_DONE);
    end
    mul_signed          = mul_signed_q;
    mul_a               = {mul_signed_q & a_q[31], a_q};
    mul_b               = {mul_signed_q & b_q[31], b_q};
    div_signed          = div_signed_q;
    div_dividend_tdata  = a_q;
    div_divisor_tdata   = b_q;
    div_dividend_tvalid = dvd_valid_q;
    div_divisor_tvalid  = dvs_valid_q;
    hi_out              = hi_q;
    lo_out              = lo_q;
    dbg_state           = state_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: one DUT with MUL_LAT=1 plus a divider model,
// and a second DUT with MUL_LAT=0 for the combinational-multiplier case.
module tb_muldiv_ctrl;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MUL_WAIT  = 3'd1;
  localparam logic [2:0] ST_DIV_DRAIN = 3'd4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;

  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        stall, mul_signed, div_signed, hilo_we;
  logic [32:0] mul_a, mul_b;
  logic [63:0] mul_p;
  logic [31:0] div_dividend_tdata, div_divisor_tdata, hi_out, lo_out;
  logic        div_dividend_tvalid, div_divisor_tvalid;
  logic        div_dividend_tready, div_divisor_tready, div_dout_tvalid;
  logic [63:0] div_dout_tdata;
  logic [2:0]  dbg_state;

  logic        z_op_valid = 1'b0;
  logic        z_ready = 1'b1;
  logic        z_dout_tvalid = 1'b0;
  logic [63:0] z_dout_tdata = '0;
  logic        z_stall, z_mul_signed, z_div_signed, z_hilo_we;
  logic [32:0] z_mul_a, z_mul_b;
  logic [63:0] z_mul_p;
  logic [31:0] z_dvd_tdata, z_dvs_tdata, z_hi, z_lo;
  logic        z_dvd_tvalid, z_dvs_tvalid;
  logic [2:0]  z_dbg_state;

  muldiv_ctrl #(.MUL_LAT(1)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall(stall), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .div_signed(div_signed), .div_dividend_tdata(div_dividend_tdata),
    .div_divisor_tdata(div_divisor_tdata), .div_dividend_tvalid(div_dividend_tvalid),
    .div_divisor_tvalid(div_divisor_tvalid), .div_dividend_tready(div_dividend_tready),
    .div_divisor_tready(div_divisor_tready), .div_dout_tvalid(div_dout_tvalid),
    .div_dout_tdata(div_dout_tdata), .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out),
    .dbg_state(dbg_state)
  );

  muldiv_ctrl #(.MUL_LAT(0)) dut_z (
    .clk(clk), .resetn(resetn), .op_valid(z_op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall(z_stall), .mul_signed(z_mul_signed), .mul_a(z_mul_a), .mul_b(z_mul_b),
    .mul_p(z_mul_p), .div_signed(z_div_signed), .div_dividend_tdata(z_dvd_tdata),
    .div_divisor_tdata(z_dvs_tdata), .div_dividend_tvalid(z_dvd_tvalid),
    .div_divisor_tvalid(z_dvs_tvalid), .div_dividend_tready(z_ready),
    .div_divisor_tready(z_ready), .div_dout_tvalid(z_dout_tvalid),
    .div_dout_tdata(z_dout_tdata), .hilo_we(z_hilo_we), .hi_out(z_hi), .lo_out(z_lo),
    .dbg_state(z_dbg_state)
  );

  // Multiplier models: one register stage for dut, purely combinational for dut_z.
  logic [63:0] mul_prod;
  logic [63:0] mul_p_q = '0;
  assign mul_prod = 64'($signed(mul_a)) * 64'($signed(mul_b));
  always @(posedge clk) mul_p_q <= mul_prod;
  assign mul_p   = mul_p_q;
  assign z_mul_p = 64'($signed(z_mul_a)) * 64'($signed(z_mul_b));

  // Divider model: per-channel tready delay, fixed result latency, no back-pressure.
  int          dvd_delay = 0;
  int          dvs_delay = 0;
  int          div_lat = 8;
  int          dvd_wait, dvs_wait, dout_cnt;
  logic        have_dvd, have_dvs, m_signed;
  logic [31:0] m_dvd, m_dvs, m_q, m_r;
  logic [63:0] m_result;

  initial begin
    div_dividend_tready = 1'b0;
    div_divisor_tready  = 1'b0;
    div_dout_tvalid     = 1'b0;
    div_dout_tdata      = '0;
    dvd_wait = 0; dvs_wait = 0; dout_cnt = 0;
    have_dvd = 1'b0; have_dvs = 1'b0; m_signed = 1'b0;
    m_dvd = '0; m_dvs = '0; m_q = '0; m_r = '0; m_result = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        div_dividend_tready = 1'b0;
        div_divisor_tready  = 1'b0;
        div_dout_tvalid     = 1'b0;
        dvd_wait = 0; dvs_wait = 0; dout_cnt = 0;
        have_dvd = 1'b0; have_dvs = 1'b0;
      end else begin
        div_dout_tvalid = 1'b0;
        if (dout_cnt > 0) begin
          dout_cnt--;
          if (dout_cnt == 0) begin
            div_dout_tvalid = 1'b1;
            div_dout_tdata  = m_result;
          end
        end
        if (div_dividend_tvalid) begin
          if (dvd_wait < dvd_delay) begin
            div_dividend_tready = 1'b0;
            dvd_wait++;
          end else begin
            div_dividend_tready = 1'b1;
            have_dvd = 1'b1;
            m_dvd    = div_dividend_tdata;
            m_signed = div_signed;
          end
        end else begin
          div_dividend_tready = 1'b0;
          dvd_wait = 0;
        end
        if (div_divisor_tvalid) begin
          if (dvs_wait < dvs_delay) begin
            div_divisor_tready = 1'b0;
            dvs_wait++;
          end else begin
            div_divisor_tready = 1'b1;
            have_dvs = 1'b1;
            m_dvs    = div_divisor_tdata;
          end
        end else begin
          div_divisor_tready = 1'b0;
          dvs_wait = 0;
        end
        if (have_dvd && have_dvs) begin
          if (m_dvs == 32'd0) begin
            m_q = '1;
            m_r = m_dvd;
          end else if (m_signed) begin
            m_q = $signed(m_dvd) / $signed(m_dvs);
            m_r = $signed(m_dvd) % $signed(m_dvs);
          end else begin
            m_q = m_dvd / m_dvs;
            m_r = m_dvd % m_dvs;
          end
          m_result = {m_q, m_r};
          dout_cnt = div_lat;
          have_dvd = 1'b0;
          have_dvs = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (hilo_we === 1'b1) we_cnt++;
    end
  end

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ((stall | mul_signed | (|mul_a) | (|mul_b) | div_signed | (|div_dividend_tdata) |
         (|div_divisor_tdata) | div_dividend_tvalid | div_divisor_tvalid | hilo_we |
         (|hi_out) | (|lo_out) | (|dbg_state)) !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs stall=%b hilo_we=%b hi=%h lo=%h state=%0d required all zero",
               stall, hilo_we, hi_out, lo_out, dbg_state);
    end
    checks++;
    if ((z_stall | z_mul_signed | (|z_mul_a) | (|z_mul_b) | z_div_signed | (|z_dvd_tdata) |
         (|z_dvs_tdata) | z_dvd_tvalid | z_dvs_tvalid | z_hilo_we | (|z_hi) | (|z_lo) |
         (|z_dbg_state)) !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs_lat0 stall=%b hilo_we=%b hi=%h lo=%h required all zero",
               z_stall, z_hilo_we, z_hi, z_lo);
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0 || hilo_we !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_idle stall=%b hilo_we=%b state=%0d required 0 0 0", stall, hilo_we, dbg_state);
    end
    @(negedge clk); op_valid = 1'b1; op = 3'd5; src_a = 32'd9; src_b = 32'd9; #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL ignored_op_stall got=%b required=0", stall);
    end
    @(negedge clk); op_valid = 1'b0; #1;
    checks++;
    if (dbg_state !== ST_IDLE || mul_a !== 33'd0 || we_cnt !== 0) begin
      failures++;
      $display("FAIL ignored_op_state state=%0d mul_a=%h we=%0d required 0 0 0", dbg_state, mul_a, we_cnt);
    end
  endtask

  task automatic test_mult;
    int we0;
    we0 = we_cnt;
    @(negedge clk); op_valid = 1'b1; op = 3'd0; src_a = 32'hFFFF_FFFD; src_b = 32'd5; #1;
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++;
      if (stall !== 1'b1 || hilo_we !== 1'b0) begin
        failures++;
        $display("FAIL mult_stall c=%0d stall=%b hilo_we=%b required 1 0", c, stall, hilo_we);
      end
      if (c == 1) begin
        checks++;
        if (mul_signed !== 1'b1 || mul_a !== 33'h1_FFFF_FFFD || mul_b !== 33'h0_0000_0005) begin
          failures++;
          $display("FAIL mult_operands signed=%b a=%h b=%h required 1 1fffffffd 000000005",
                   mul_signed, mul_a, mul_b);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (hilo_we !== 1'b1 || stall !== 1'b0 || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFF1) begin
      failures++;
      $display("FAIL mult_write we=%b stall=%b hi=%h lo=%h required 1 0 ffffffff fffffff1",
               hilo_we, stall, hi_out, lo_out);
    end
    @(negedge clk); op_valid = 1'b0; #1;
    checks++;
    if (hilo_we !== 1'b0 || stall !== 1'b0 || dbg_state !== ST_IDLE || (we_cnt - we0) !== 1) begin
      failures++;
      $display("FAIL mult_after we=%b stall=%b state=%0d writes=%0d required 0 0 0 1",
               hilo_we, stall, dbg_state, we_cnt - we0);
    end
  endtask

  task automatic test_multu;
    @(negedge clk); op_valid = 1'b1; op = 3'd1; src_a = 32'hFFFF_FFFF; src_b = 32'd2; #1;
    @(negedge clk); #1;
    checks++;
    if (mul_signed !== 1'b0 || mul_a !== 33'h0_FFFF_FFFF || mul_b !== 33'h0_0000_0002 || stall !== 1'b1) begin
      failures++;
      $display("FAIL multu_operands signed=%b a=%h b=%h stall=%b required 0 0ffffffff 000000002 1",
               mul_signed, mul_a, mul_b, stall);
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (hilo_we !== 1'b1 || hi_out !== 32'h0000_0001 || lo_out !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL multu_write we=%b hi=%h lo=%h required 1 00000001 fffffffe", hilo_we, hi_out, lo_out);
    end
    @(negedge clk); op_valid = 1'b0; #1;
  endtask

  task automatic test_multu_lat0;
    @(negedge clk); z_op_valid = 1'b1; op = 3'd1; src_a = 32'hFFFF_FFFF; src_b = 32'd2; #1;
    checks++;
    if (z_stall !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL lat0_accept z_stall=%b stall=%b required 1 0", z_stall, stall);
    end
    @(negedge clk); #1;
    checks++;
    if (z_stall !== 1'b1 || z_hilo_we !== 1'b0 || z_dbg_state !== ST_MUL_WAIT) begin
      failures++;
      $display("FAIL lat0_wait stall=%b we=%b state=%0d required 1 0 1", z_stall, z_hilo_we, z_dbg_state);
    end
    @(negedge clk); #1;
    checks++;
    if (z_hilo_we !== 1'b1 || z_stall !== 1'b0 || z_hi !== 32'h0000_0001 || z_lo !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL lat0_write we=%b stall=%b hi=%h lo=%h required 1 0 00000001 fffffffe",
               z_hilo_we, z_stall, z_hi, z_lo);
    end
    @(negedge clk); z_op_valid = 1'b0; #1;
    checks++;
    if (z_hilo_we !== 1'b0 || z_dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL lat0_after we=%b state=%0d required 0 0", z_hilo_we, z_dbg_state);
    end
  endtask

  task automatic test_div;
    int we0;
    we0 = we_cnt;
    dvd_delay = 3; dvs_delay = 0; div_lat = 8;
    @(negedge clk); op_valid = 1'b1; op = 3'd2; src_a = 32'hFFFF_FFF9; src_b = 32'd2; #1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      checks++;
      if (div_dividend_tvalid !== (c <= 4) || div_divisor_tvalid !== (c == 1) ||
          stall !== 1'b1 || hilo_we !== 1'b0) begin
        failures++;
        $display("FAIL div_seq c=%0d dvd_v=%b dvs_v=%b stall=%b we=%b required %b %b 1 0",
                 c, div_dividend_tvalid, div_divisor_tvalid, stall, hilo_we, c <= 4, c == 1);
      end
      if (c == 1) begin
        checks++;
        if (div_signed !== 1'b1 || div_dividend_tdata !== 32'hFFFF_FFF9 || div_divisor_tdata !== 32'd2) begin
          failures++;
          $display("FAIL div_operands signed=%b dvd=%h dvs=%h required 1 fffffff9 00000002",
                   div_signed, div_dividend_tdata, div_divisor_tdata);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (hilo_we !== 1'b1 || stall !== 1'b0 || lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_write we=%b stall=%b lo=%h hi=%h required 1 0 fffffffd ffffffff",
               hilo_we, stall, lo_out, hi_out);
    end
    @(negedge clk); op_valid = 1'b0; #1;
    checks++;
    if ((we_cnt - we0) !== 1 || hilo_we !== 1'b0) begin
      failures++;
      $display("FAIL div_single_write writes=%0d we=%b required 1 0", we_cnt - we0, hilo_we);
    end
  endtask

  task automatic test_flush_wait;
    int we0;
    dvd_delay = 0; dvs_delay = 0; div_lat = 8;
    we0 = we_cnt;
    @(negedge clk); op_valid = 1'b1; op = 3'd3; src_a = 32'd50; src_b = 32'd5; #1;
    repeat (3) begin @(negedge clk); #1; end
    @(negedge clk); flush = 1'b1; #1;
    checks++;
    if (stall !== 1'b0 || hilo_we !== 1'b0) begin
      failures++;
      $display("FAIL flushw_flush stall=%b we=%b required 0 0", stall, hilo_we);
    end
    @(negedge clk); flush = 1'b0; op_valid = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7; #1;
    checks++;
    if (dbg_state !== ST_DIV_DRAIN) begin
      failures++;
      $display("FAIL flushw_drain state=%0d required 4", dbg_state);
    end
    for (int c = 5; c <= 10; c++) begin
      if (c > 5) begin @(negedge clk); #1; end
      checks++;
      if (stall !== 1'b1 || div_dividend_tvalid !== 1'b0 || div_divisor_tvalid !== 1'b0 ||
          hilo_we !== 1'b0 || lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin
        failures++;
        $display("FAIL flushw_hold c=%0d stall=%b dvd_v=%b dvs_v=%b we=%b lo=%h hi=%h required 1 0 0 0 fffffffd ffffffff",
                 c, stall, div_dividend_tvalid, div_divisor_tvalid, hilo_we, lo_out, hi_out);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (div_dividend_tvalid !== 1'b1 || div_divisor_tvalid !== 1'b1 || div_dividend_tdata !== 32'd100) begin
      failures++;
      $display("FAIL flushw_reissue dvd_v=%b dvs_v=%b dvd=%h required 1 1 00000064",
               div_dividend_tvalid, div_divisor_tvalid, div_dividend_tdata);
    end
    for (int k = 0; k < 30 && hilo_we !== 1'b1; k++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (hilo_we !== 1'b1 || lo_out !== 32'd14 || hi_out !== 32'd2 || (we_cnt - we0) !== 0) begin
      failures++;
      $display("FAIL flushw_divu we=%b lo=%h hi=%h prior_writes=%0d required 1 0000000e 00000002 0",
               hilo_we, lo_out, hi_out, we_cnt - we0);
    end
    @(negedge clk); op_valid = 1'b0; #1;
  endtask

  task automatic test_flush_send;
    int we0;
    dvd_delay = 3; dvs_delay = 0; div_lat = 8;
    we0 = we_cnt;
    @(negedge clk); op_valid = 1'b1; op = 3'd2; src_a = 32'd20; src_b = 32'd3; #1;
    @(negedge clk); #1;
    @(negedge clk); flush = 1'b1; #1;
    checks++;
    if (stall !== 1'b0 || div_dividend_tvalid !== 1'b1 || div_divisor_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL flushs_flush stall=%b dvd_v=%b dvs_v=%b required 0 1 0",
               stall, div_dividend_tvalid, div_divisor_tvalid);
    end
    @(negedge clk); flush = 1'b0; op_valid = 1'b0; #1;
    checks++;
    if (div_dividend_tvalid !== 1'b1 || stall !== 1'b1) begin
      failures++;
      $display("FAIL flushs_hold_valid dvd_v=%b stall=%b required 1 1", div_dividend_tvalid, stall);
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (div_dividend_tvalid !== 1'b0 || dbg_state !== ST_DIV_DRAIN || stall !== 1'b0) begin
      failures++;
      $display("FAIL flushs_drain dvd_v=%b state=%0d stall=%b required 0 4 0",
               div_dividend_tvalid, dbg_state, stall);
    end
    repeat (8) begin @(negedge clk); #1; end
    checks++;
    if (dbg_state !== ST_IDLE || (we_cnt - we0) !== 0 || lo_out !== 32'd14 || hi_out !== 32'd2) begin
      failures++;
      $display("FAIL flushs_end state=%0d writes=%0d lo=%h hi=%h required 0 0 0000000e 00000002",
               dbg_state, we_cnt - we0, lo_out, hi_out);
    end
  endtask

  task automatic test_back_to_back;
    int we0;
    we0 = we_cnt;
    @(negedge clk); op_valid = 1'b1; op = 3'd0; src_a = 32'd7; src_b = 32'hFFFF_FFFE; #1;
    repeat (3) begin @(negedge clk); #1; end
    checks++;
    if (hilo_we !== 1'b1 || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFF2) begin
      failures++;
      $display("FAIL b2b_first we=%b hi=%h lo=%h required 1 ffffffff fffffff2", hilo_we, hi_out, lo_out);
    end
    @(negedge clk); op = 3'd1; src_a = 32'h8000_0000; src_b = 32'd4; #1;
    checks++;
    if (stall !== 1'b1 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL b2b_accept stall=%b state=%0d required 1 0", stall, dbg_state);
    end
    @(negedge clk); #1;
    checks++;
    if (dbg_state !== ST_MUL_WAIT || mul_a !== 33'h0_8000_0000) begin
      failures++;
      $display("FAIL b2b_second_op state=%0d mul_a=%h required 1 080000000", dbg_state, mul_a);
    end
    repeat (2) begin @(negedge clk); #1; end
    checks++;
    if (hilo_we !== 1'b1 || hi_out !== 32'h0000_0002 || lo_out !== 32'h0000_0000) begin
      failures++;
      $display("FAIL b2b_second we=%b hi=%h lo=%h required 1 00000002 00000000", hilo_we, hi_out, lo_out);
    end
    @(negedge clk); op_valid = 1'b0; #1;
    checks++;
    if ((we_cnt - we0) !== 2) begin
      failures++;
      $display("FAIL b2b_writes got=%0d required=2", we_cnt - we0);
    end
  endtask

  task automatic test_async_reset;
    dvd_delay = 3; dvs_delay = 0; div_lat = 8;
    @(negedge clk); op_valid = 1'b1; op = 3'd2; src_a = 32'd40; src_b = 32'd6; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    resetn = 1'b0; op_valid = 1'b0; #1;
    checks++;
    if ((stall | mul_signed | (|mul_a) | div_signed | (|div_dividend_tdata) | div_dividend_tvalid |
         div_divisor_tvalid | hilo_we | (|hi_out) | (|lo_out) | (|dbg_state)) !== 1'b0) begin
      failures++;
      $display("FAIL async_reset stall=%b dvd_v=%b hi=%h lo=%h state=%0d required all zero",
               stall, div_dividend_tvalid, hi_out, lo_out, dbg_state);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (12) begin @(negedge clk); #1; end
    checks++;
    if (dbg_state !== ST_IDLE || stall !== 1'b0 || hilo_we !== 1'b0 || div_dividend_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL async_release state=%0d stall=%b we=%b dvd_v=%b required 0 0 0 0",
               dbg_state, stall, hilo_we, div_dividend_tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_multu_lat0();
    test_div();
    test_flush_wait();
    test_flush_send();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
